bias_seq_ctrl: RTL and testbench

//  Initiator side of the single-IO bias handshake (enable -> ready/biased_out).

---
 rtl/bias_pkg.sv | 21 ++
 rtl/bias_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_bias_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_pkg.sv
// Shared types and default sizing for the bias sequencing controller.
package bias_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_TIMEOUT   = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } bias_state_t;

  // Index width that stays legal for a single-entry configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_seq_ctrl.sv
// Initiator for the single-IO bias handshake: issues N input/bias pairs in turn and buffers results.
// Optional BIAS_TIMEOUT_EN adds a per-slot ready timeout with a sticky error flag.
//
//  state | meaning
//  IDLE  | waiting for start; slot buffers writable
//  ISSUE | one-cycle bias_enable pulse for slot idx
//  WAIT  | waiting for a rising edge on bias_ready
//  STORE | commit captured result to result[idx], advance or finish
//  DONE  | one-cycle completion pulse, busy already low
module bias_seq_ctrl
  import bias_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  localparam int IDX_W    = idx_width(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [WIDTH-1:0] load_in,
  input  logic [WIDTH-1:0] load_bias,
  input  logic             start,
  output logic             bias_enable,
  output logic [WIDTH-1:0] bias_in,
  output logic [WIDTH-1:0] bias_val,
  input  logic             bias_ready,
  input  logic [WIDTH-1:0] bias_out,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Buffers are sized to the full index range so any index decodes safely.
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  bias_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [WIDTH-1:0] in_mem   [DEPTH];
  logic [WIDTH-1:0] bias_mem [DEPTH];
  logic [WIDTH-1:0] res_mem  [DEPTH];
  logic [WIDTH-1:0] captured;
  logic [WIDTH-1:0] first_in;
  logic [WIDTH-1:0] first_bias;
  logic             ready_q;
  logic             ready_rise;
  logic             load_ok;

  assign ready_rise = bias_ready & ~ready_q;
  assign load_ok    = load_valid && (state == IDLE || state == DONE);
  assign next_idx   = idx + 1'b1;
  assign rd_data    = res_mem[rd_idx];

  // A slot-0 write in the start cycle must reach the first issue.
  assign first_in   = (load_ok && load_idx == '0) ? load_in   : in_mem[0];
  assign first_bias = (load_ok && load_idx == '0) ? load_bias : bias_mem[0];

`ifdef BIAS_TIMEOUT_EN
  localparam int TMO_W = idx_width(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             error_q;

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    ready_q <= bias_ready;
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      bias_enable <= 1'b0;
      bias_in     <= '0;
      bias_val    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      captured    <= '0;
      ready_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        in_mem[i]   <= '0;
        bias_mem[i] <= '0;
        res_mem[i]  <= '0;
      end
`ifdef BIAS_TIMEOUT_EN
      tmo_cnt <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      bias_enable <= 1'b0;
      done        <= 1'b0;
      if (load_ok) begin
        in_mem[load_idx]   <= load_in;
        bias_mem[load_idx] <= load_bias;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            idx         <= '0;
            busy        <= 1'b1;
            bias_enable <= 1'b1;
            bias_in     <= first_in;
            bias_val    <= first_bias;
`ifdef BIAS_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef BIAS_TIMEOUT_EN
          tmo_cnt <= TMO_LOAD;
`endif
        end
        WAIT: begin
          if (ready_rise) begin
            captured <= bias_out;
            state    <= STORE;
          end
`ifdef BIAS_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            captured <= '0;
            error_q  <= 1'b1;
            state    <= STORE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        STORE: begin
          res_mem[idx] <= captured;
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
          end else begin
            idx         <= next_idx;
            state       <= ISSUE;
            bias_enable <= 1'b1;
            bias_in     <= in_mem[next_idx];
            bias_val    <= bias_mem[next_idx];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Self-checking bench for bias_seq_ctrl with a behavioural responder and result model.
`timescale 1ns/1ps
module tb_bias_seq_ctrl;
  import bias_pkg::*;

  localparam int N   = DEF_N_NEURONS;
  localparam int W   = DEF_WIDTH;
  localparam int IW  = idx_width(N);
  localparam int TMO = DEF_TIMEOUT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [W-1:0]  load_in = '0;
  logic [W-1:0]  load_bias = '0;
  logic          start = 1'b0;
  logic          bias_enable;
  logic [W-1:0]  bias_in;
  logic [W-1:0]  bias_val;
  logic          bias_ready = 1'b0;
  logic [W-1:0]  bias_out = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  bias_seq_ctrl dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_idx(load_idx),
    .load_in(load_in), .load_bias(load_bias), .start(start),
    .bias_enable(bias_enable), .bias_in(bias_in), .bias_val(bias_val),
    .bias_ready(bias_ready), .bias_out(bias_out), .rd_idx(rd_idx),
    .rd_data(rd_data), .busy(busy), .done(done), .error(error)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Responder: after each enable, optionally holds a stale high level for
  // resp_hold cycles, then presents in+bias with a rising ready after resp_lat.
  int          resp_lat = 2;
  int          resp_hold = 0;
  int          resp_silent = -1;
  int          r_hold = 0;
  int          r_cnt = 0;
  int          r_slot = 0;
  logic        r_pend = 1'b0;
  logic [W-1:0] r_val = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bias_ready = 1'b0;
      r_pend = 1'b0;
      r_slot = 0;
    end else begin
      if (done) r_slot = 0;
      if (bias_enable) begin
        r_val  = bias_in + bias_val;
        r_hold = resp_hold;
        r_cnt  = resp_lat;
        r_pend = (r_slot != resp_silent);
        if (!r_pend || resp_hold == 0) bias_ready = 1'b0;
        else begin
          bias_ready = 1'b1;
          bias_out = 8'hEE;
        end
        r_slot++;
      end else if (r_pend) begin
        if (r_hold > 0) begin
          r_hold--;
          if (r_hold == 0) bias_ready = 1'b0;
        end else if (r_cnt > 1) r_cnt--;
        else begin
          bias_ready = 1'b1;
          bias_out = r_val;
          r_pend = 1'b0;
        end
      end
    end
  end

  int   en_total = 0;
  int   en_wide = 0;
  int   done_total = 0;
  logic en_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bias_enable) en_total++;
    if (bias_enable && en_prev) en_wide++;
    en_prev = bias_enable;
    if (done) done_total++;
  end

  logic [W-1:0] m_in   [N];
  logic [W-1:0] m_bias [N];
  logic [W-1:0] m_res  [N];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    load_valid = 1'b1;
    load_idx = IW'(i);
    load_in = a;
    load_bias = b;
    tick();
    load_valid = 1'b0;
    m_in[i] = a;
    m_bias[i] = b;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      #1;
      check($sformatf("%s_res%0d", tag, i), 32'(rd_data), 32'(m_res[i]));
    end
  endtask

  task automatic run(input string tag, input int lat, input int hold, input int silent,
                     input bit disturb, input bit ld0, input logic [W-1:0] ld_in,
                     input logic [W-1:0] ld_bias);
    int e0, w0, d0, exp_cyc, cyc;
    resp_lat = lat;
    resp_hold = hold;
    resp_silent = silent;
    e0 = en_total;
    w0 = en_wide;
    d0 = done_total;
    if (ld0) begin
      load_valid = 1'b1;
      load_idx = '0;
      load_in = ld_in;
      load_bias = ld_bias;
      m_in[0] = ld_in;
      m_bias[0] = ld_bias;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    check({tag, "_busy_on"}, 32'(busy), 1);
    check({tag, "_enable_on"}, 32'(bias_enable), 1);
    check({tag, "_err_clr"}, 32'(error), 0);
    exp_cyc = 0;
    for (int i = 0; i < N; i++) exp_cyc += (i == silent) ? TMO + 2 : hold + lat + 2;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (disturb && cyc == 3) begin
        start = 1'b1;
        load_valid = 1'b1;
        load_idx = IW'(1);
        load_in = 8'd99;
        load_bias = 8'd7;
      end else begin
        start = 1'b0;
        load_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    load_valid = 1'b0;
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    tick();
    check({tag, "_done_width"}, 32'(done), 0);
    check({tag, "_enable_count"}, 32'(en_total - e0), 32'(N));
    check({tag, "_enable_wide"}, 32'(en_wide - w0), 0);
    check({tag, "_done_count"}, 32'(done_total - d0), 1);
    for (int i = 0; i < N; i++) m_res[i] = (i == silent) ? '0 : W'(m_in[i] + m_bias[i]);
    check_results(tag);
  endtask

  initial begin
    int e0, k;
    for (int i = 0; i < N; i++) begin
      m_in[i] = '0;
      m_bias[i] = '0;
      m_res[i] = '0;
    end

    rst = 1'b1;
    tick();
    tick();
    check("rst_enable", 32'(bias_enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_bias_in", 32'(bias_in), 0);
    check("rst_bias_val", 32'(bias_val), 0);
    check_results("rst");
    rst = 1'b0;
    tick();

    load_slot(0, 8'd5, 8'd5);
    load_slot(1, 8'd10, 8'd1);
    load_slot(2, 8'd20, 8'd2);
    load_slot(3, 8'd30, 8'd3);
    run("basic", 2, 0, -1, 1'b0, 1'b0, '0, '0);
    rd_idx = IW'(3);
    #1;
    check("basic_r3_const", 32'(rd_data), 33);

    run("stale", 1, 3, -1, 1'b0, 1'b0, '0, '0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) load_slot(i, W'($urandom), W'($urandom));
      run($sformatf("rand%0d", r), $urandom_range(1, 4), $urandom_range(0, 2), -1,
          1'b0, 1'b0, '0, '0);
    end

    run("disturb", 1, 0, -1, 1'b1, 1'b0, '0, '0);
    run("after_disturb", 2, 0, -1, 1'b0, 1'b0, '0, '0);

    load_slot(2, 8'd250, 8'd10);
    run("overflow", 3, 0, -1, 1'b0, 1'b0, '0, '0);
    rd_idx = IW'(2);
    #1;
    check("overflow_r2_const", 32'(rd_data), 4);

    run("start_load", 1, 0, -1, 1'b0, 1'b1, W'($urandom), W'($urandom));

`ifdef BIAS_TIMEOUT_EN
    run("timeout", 2, 0, 1, 1'b0, 1'b0, '0, '0);
    check("timeout_error_set", 32'(error), 1);
    run("timeout_clear", 2, 0, -1, 1'b0, 1'b0, '0, '0);
    check("timeout_error_after", 32'(error), 0);
`else
    check("no_timeout_error", 32'(error), 0);
`endif

    resp_lat = 10;
    resp_hold = 0;
    resp_silent = -1;
    e0 = en_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (en_total - e0 < 3 && k < 200) begin
      tick();
      k++;
    end
    check("rst_mid_reach_slot2", 32'(en_total - e0), 3);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_enable", 32'(bias_enable), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_error", 32'(error), 0);
    check("rst_mid_bias_in", 32'(bias_in), 0);
    check("rst_mid_bias_val", 32'(bias_val), 0);
    for (int i = 0; i < N; i++) begin
      m_in[i] = '0;
      m_bias[i] = '0;
      m_res[i] = '0;
    end
    check_results("rst_mid");
    rst = 1'b0;
    e0 = en_total;
    for (int i = 0; i < 8; i++) tick();
    check("rst_mid_no_enable", 32'(en_total - e0), 0);
    check("rst_mid_idle", 32'(busy), 0);

    for (int i = 0; i < N; i++) load_slot(i, W'($urandom), W'($urandom));
    run("post_rst", $urandom_range(1, 4), 0, -1, 1'b0, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
